cp0_exc_ctrl: RTL

CP0 register-file owner and exception/ERET sequencer for the dual-issue core. It holds BadVAddr, Count, Compare, Status, Cause and EPC, and applies MTC0 writes coming from the COP0 execution unit. It runs the Count/Compare timer and raises interrupt requests. It accepts exception and ERET events from the commit stage and drives the fetch-redirect handshake.

---
 rtl/cp0_exc_ctrl_pkg.sv | 52 +++++
 rtl/cp0_exc_ctrl_timer.sv | 72 +++++++
 rtl/cp0_exc_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/cp0_exc_ctrl_pkg.sv
// cp0_exc_ctrl_pkg
//   Shared definitions for the CP0 register owner: the register-file view
//   exported to MFC0 / the COP0 unit, MTC0 register selectors, exception
//   codes and Status/Cause bit positions.
package cp0_exc_ctrl_pkg;

    typedef struct packed {
        logic [31:0] badvaddr;
        logic [31:0] count;
        logic [31:0] compare;
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] epc;
    } cp0_regfile_t;

    // MTC0 / MFC0 selectors, encoded as {rd[4:0], sel[2:0]}
    localparam logic [7:0] RS_NONE     = 8'h00;
    localparam logic [7:0] RS_BADVADDR = 8'h40;
    localparam logic [7:0] RS_COUNT    = 8'h48;
    localparam logic [7:0] RS_COMPARE  = 8'h58;
    localparam logic [7:0] RS_STATUS   = 8'h60;
    localparam logic [7:0] RS_CAUSE    = 8'h68;
    localparam logic [7:0] RS_EPC      = 8'h70;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    // Status bit positions
    localparam int STATUS_BEV    = 22;
    localparam int STATUS_IM_LO  = 8;
    localparam int STATUS_IM_HI  = 15;
    localparam int STATUS_EXL    = 1;
    localparam int STATUS_IE     = 0;

    // Cause bit positions
    localparam int CAUSE_BD      = 31;
    localparam int CAUSE_TI      = 30;
    localparam int CAUSE_IP_LO   = 8;
    localparam int CAUSE_IP_HI   = 15;
    localparam int CAUSE_EXC_LO  = 2;
    localparam int CAUSE_EXC_HI  = 6;

    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

endpackage

// File: rtl/cp0_exc_ctrl_timer.sv
// cp0_exc_ctrl_timer
//   Count/Compare timer. A free-running divider advances Count once every
//   COUNT_DIV cycles; TI latches one cycle after the registered Count equals
//   Compare and is cleared by any write to Compare.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   wr_count          MTC0 write to Count this cycle
//   wr_compare        MTC0 write to Compare this cycle
//   wr_data           MTC0 data
//   count, compare    current register values
//   ti                timer interrupt flag
module cp0_exc_ctrl_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_count,
    input  logic        wr_compare,
    input  logic [31:0] wr_data,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [31:0]      count_q, count_d;
    logic [31:0]      compare_q, compare_d;
    logic             ti_q, ti_d;
    logic             wrap;

    always_comb begin
        wrap      = (div_q == DIV_LAST);
        div_d     = wrap ? '0 : div_q + 1'b1;

        // A software write to Count takes precedence over the tick.
        count_d   = count_q;
        if (wr_count)
            count_d = wr_data;
        else if (wrap)
            count_d = count_q + 32'd1;

        compare_d = wr_compare ? wr_data : compare_q;

        // Match uses the registered values, so TI rises one cycle later;
        // a Compare write clears it even if a match is seen that cycle.
        ti_d      = ti_q | (count_q == compare_q);
        if (wr_compare)
            ti_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q     <= '0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            div_q     <= div_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count   = count_q;
    assign compare = compare_q;
    assign ti      = ti_q;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl
//   Owns the CP0 registers (BadVAddr, Count, Compare, Status, Cause, EPC),
//   applies MTC0 writes, runs the timer, flags pending interrupts and
//   sequences exception / ERET entry through a fetch-redirect handshake.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   exc_valid/code/pc/bd/badvaddr   exception report from commit
//   eret_valid                      ERET committed
//   wr_regsel, wr_data              MTC0 write (regsel 0 = none)
//   hw_int                          hardware interrupt lines
//   cp0_reg                         register view for MFC0
//   cp0_flush                       accept strobe (combinational)
//   int_pending                     enabled interrupt pending
//   redirect_valid/pc/ready         fetch redirect handshake
module cp0_exc_ctrl
    import cp0_exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter int          COUNT_DIV  = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         exc_valid,
    input  logic [4:0]   exc_code,
    input  logic [31:0]  exc_pc,
    input  logic         exc_bd,
    input  logic [31:0]  exc_badvaddr,
    input  logic         eret_valid,
    input  logic [7:0]   wr_regsel,
    input  logic [31:0]  wr_data,
    input  logic [5:0]   hw_int,
    output cp0_regfile_t cp0_reg,
    output logic         cp0_flush,
    output logic         int_pending,
    output logic         redirect_valid,
    output logic [31:0]  redirect_pc,
    input  logic         redirect_ready
);

    localparam logic [0:0] S_IDLE     = 1'b0;
    localparam logic [0:0] S_REDIRECT = 1'b1;

    logic [0:0]  state_q, state_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] epc_q, epc_d;
    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [4:0]  excode_q, excode_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [5:0]  hw_q;

    logic        exc_accept, eret_accept, mtc0_en;
    logic        wr_count, wr_compare;
    logic [31:0] count, compare;
    logic        ti;
    logic [7:0]  ip;
    logic [31:0] status_rd, cause_rd;

    always_comb begin
        exc_accept  = (state_q == S_IDLE) && exc_valid;
        eret_accept = (state_q == S_IDLE) && eret_valid && !exc_valid;
        cp0_flush   = exc_accept || eret_accept;
        // MTC0 is squashed in any accept cycle, including the timer writes.
        mtc0_en     = (wr_regsel != RS_NONE) && !cp0_flush;
        wr_count    = mtc0_en && (wr_regsel == RS_COUNT);
        wr_compare  = mtc0_en && (wr_regsel == RS_COMPARE);
    end

    cp0_exc_ctrl_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .wr_count   (wr_count),
        .wr_compare (wr_compare),
        .wr_data    (wr_data),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );

    always_comb begin
        ip        = {hw_q[5] | ti, hw_q[4:0], ip_sw_q};
        status_rd = 32'd0;
        status_rd[STATUS_BEV]                 = 1'b1;
        status_rd[STATUS_IM_HI:STATUS_IM_LO]  = im_q;
        status_rd[STATUS_EXL]                 = exl_q;
        status_rd[STATUS_IE]                  = ie_q;
        cause_rd  = 32'd0;
        cause_rd[CAUSE_BD]                    = bd_q;
        cause_rd[CAUSE_TI]                    = ti;
        cause_rd[CAUSE_IP_HI:CAUSE_IP_LO]     = ip;
        cause_rd[CAUSE_EXC_HI:CAUSE_EXC_LO]   = excode_q;
        int_pending = ie_q && !exl_q && |(ip & im_q);
    end

    always_comb begin
        state_d          = state_q;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;
        badvaddr_d       = badvaddr_q;
        epc_d            = epc_q;
        im_d             = im_q;
        exl_d            = exl_q;
        ie_d             = ie_q;
        bd_d             = bd_q;
        excode_d         = excode_q;
        ip_sw_d          = ip_sw_q;

        if (exc_accept) begin
            excode_d = exc_code;
            exl_d    = 1'b1;
            // Nested exceptions keep the original return point.
            if (!exl_q) begin
                epc_d = exc_bd ? exc_pc - 32'd4 : exc_pc;
                bd_d  = exc_bd;
            end
            if (exc_code == EXC_ADEL || exc_code == EXC_ADES)
                badvaddr_d = exc_badvaddr;
            state_d          = S_REDIRECT;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = EXC_VECTOR;
        end else if (eret_accept) begin
            exl_d            = 1'b0;
            state_d          = S_REDIRECT;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = epc_q;
        end else if (state_q == S_REDIRECT && redirect_valid_q && redirect_ready) begin
            state_d          = S_IDLE;
            redirect_valid_d = 1'b0;
        end

        if (mtc0_en) begin
            case (wr_regsel)
                RS_STATUS: begin
                    im_d  = wr_data[STATUS_IM_HI:STATUS_IM_LO];
                    exl_d = wr_data[STATUS_EXL];
                    ie_d  = wr_data[STATUS_IE];
                end
                RS_CAUSE: ip_sw_d = wr_data[9:8];
                RS_EPC:   epc_d   = wr_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            badvaddr_q       <= '0;
            epc_q            <= '0;
            im_q             <= '0;
            exl_q            <= 1'b0;
            ie_q             <= 1'b0;
            bd_q             <= 1'b0;
            excode_q         <= '0;
            ip_sw_q          <= '0;
            hw_q             <= '0;
        end else begin
            state_q          <= state_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            badvaddr_q       <= badvaddr_d;
            epc_q            <= epc_d;
            im_q             <= im_d;
            exl_q            <= exl_d;
            ie_q             <= ie_d;
            bd_q             <= bd_d;
            excode_q         <= excode_d;
            ip_sw_q          <= ip_sw_d;
            hw_q             <= hw_int;
        end
    end

    always_comb begin
        cp0_reg.badvaddr = badvaddr_q;
        cp0_reg.count    = count;
        cp0_reg.compare  = compare;
        cp0_reg.status   = status_rd;
        cp0_reg.cause    = cause_rd;
        cp0_reg.epc      = epc_q;
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule
